pattern_generator_p2s: RTL and testbench
========================================

// Module: pattern_generator_p2s
//
// PURPOSE
// - Parallel-to-serial pattern transmitter: accepts a WIDTH-bit word via valid/ready, shifts it
//   out MSB-first, one bit per clk, on string_out.
// - Stimulus/source end of the serial pattern link; string_out drives the string_in of the
//   downstream 4-bit (1101) serial pattern detector.
// - Programmable inter-word idle gap; optional sync preamble per word.
//
// PARAMETERS
// - WIDTH       8        data word width in bits (>= 2)
// - GAP         1        idle cycles after each word's last bit before next accept (>= 0)
// - IDLE_LEVEL  1'b0     value driven on string_out when no bit is being sent
// - PREAMBLE    4'b1101  sync nibble sent before each word (used only with PREAMBLE_EN)
//
// PORTS
// - clk         in   1      single clock, all logic on posedge
// - reset       in   1      synchronous, active-high reset
// - data_in     in   WIDTH  word to transmit, sampled on accept
// - data_valid  in   1      source has a word on data_in
// - data_ready  out  1      block can accept; accept = data_valid & data_ready at posedge clk
// - string_out  out  1      serial bitstream, registered
// - busy        out  1      high from cycle after accept until last gap cycle ends
// - word_done   out  1      one-cycle pulse while last data bit is on string_out
//
// BEHAVIOUR
// - Reset (sync, active-high): string_out=IDLE_LEVEL, data_ready=1, busy=0, word_done=0,
//   FSM=IDLE, counters cleared. Reset mid-word aborts it; no partial word resumes.
// - FSM: IDLE -> (accept) -> [PRE] -> SHIFT -> GAP (if GAP>0) -> IDLE.
//   IDLE: string_out=IDLE_LEVEL, data_ready=1. Accept loads shift reg, clears bit counter.
//   SHIFT: string_out = shreg[WIDTH-1]; shift left each cycle; counter 0..WIDTH-1.
//   Last bit (count==WIDTH-1): word_done=1; next state GAP, or IDLE if GAP==0.
//   GAP: string_out=IDLE_LEVEL, data_ready=0 for exactly GAP cycles.
// - Latency: first data bit on string_out in cycle accept+1 (no preamble); word occupies
//   WIDTH consecutive cycles, no bubbles.
// - Back-to-back (GAP==0 only): data_ready also high during the last-bit cycle; an accept
//   there makes the next word's MSB follow immediately — continuous stream.
// - data_ready is low in PRE, in SHIFT (except above), and in GAP; data_in/data_valid
//   ignored then. data_valid dropping mid-word has no effect.
// - Counters sized $clog2(WIDTH) and $clog2(GAP+1); no wrap beyond terminal counts.
// - busy = FSM != IDLE (and not the post-reset cycle).
//
// CONFIGURATION
// - PREAMBLE_EN defined: after accept, state PRE emits PREAMBLE[3]..PREAMBLE[0] over 4 cycles,
//   then SHIFT; first data bit at accept+5; word_done at accept+4+WIDTH. Back-to-back words
//   each get their own preamble.
// - PREAMBLE_EN undefined: PRE state and PREAMBLE logic absent; IDLE -> SHIFT directly.
//
// TESTING
// - Reset held 2 cycles, data_valid=1 -> string_out=0, data_ready=1, busy=0, word_done=0.
// - WIDTH=8, GAP=1, accept 8'hD5 at T -> string_out 1,1,0,1,0,1,0,1 in T+1..T+8;
//   word_done only at T+8; string_out=0 and data_ready=0 at T+9; data_ready=1 at T+10.
// - GAP=0, data_valid held with 8'hF0 then 8'h0F -> 16 contiguous bits 1111000000001111,
//   second accept in first word's last-bit cycle, no idle cycle between words.
// - Reset asserted during 3rd bit of 8'hFF -> next cycle string_out=0, data_ready=1, busy=0;
//   following accept of 8'hA5 transmits all 8 bits correctly.
// - Loopback to 1101 detector, accept 8'h0D -> detector output high exactly one cycle
//   after word_done, for one cycle; 8'h0B -> detector never fires within the word.
// - PREAMBLE_EN, WIDTH=8, accept 8'h00 at T -> string_out 1,1,0,1 at T+1..T+4, zeros
//   T+5..T+12, word_done at T+12; detector fires once, at T+5.

Source files
------------

// File: rtl/pattern_generator_p2s.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pattern_generator_p2s                                             |
// | Desc   : Parallel-to-serial pattern transmitter, MSB-first, with idle gap; |
// |          optional 4-bit sync preamble per word when PREAMBLE_EN is defined.|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module pattern_generator_p2s #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GAP        = 1,
    parameter logic        IDLE_LEVEL = 1'b0,
    parameter logic [3:0]  PREAMBLE   = 4'b1101
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             string_out,
    output logic             busy,
    output logic             word_done
);

    localparam int unsigned c_cnt_w = $clog2(WIDTH);
    localparam int unsigned c_gap_w = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_penult = c_cnt_w'(WIDTH - 2);
    localparam logic [c_gap_w-1:0] c_gap_last   = c_gap_w'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRE   = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_gap_w-1:0] r_gap_cnt;
    logic               r_string;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               w_accept;

`ifdef PREAMBLE_EN
    logic [3:0]         r_pre_sh;
    logic [1:0]         r_pre_cnt;
`else
    logic               w_unused_preamble;
    assign w_unused_preamble = ^PREAMBLE;
`endif

    assign w_accept = data_valid & r_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
            r_string  <= IDLE_LEVEL;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef PREAMBLE_EN
            r_pre_sh  <= '0;
            r_pre_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_string <= IDLE_LEVEL;
                end
`ifdef PREAMBLE_EN
                S_PRE: begin
                    if (r_pre_cnt == 2'd3) begin
                        r_state  <= S_SHIFT;
                        r_string <= r_shreg[WIDTH-1];
                        r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
                        r_cnt    <= '0;
                    end else begin
                        r_string  <= r_pre_sh[3];
                        r_pre_sh  <= {r_pre_sh[2:0], 1'b0};
                        r_pre_cnt <= r_pre_cnt + 2'd1;
                    end
                end
`endif
                S_SHIFT: begin
                    // r_cnt is the index of the bit currently on string_out
                    if (r_cnt == c_cnt_last) begin
                        r_done   <= 1'b0;
                        r_string <= IDLE_LEVEL;
                        if (GAP > 0) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_string <= r_shreg[WIDTH-1];
                        r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == c_cnt_penult) begin
                            r_done  <= 1'b1;
                            r_ready <= (GAP == 0);
                        end
                    end
                end
                S_GAP: begin
                    r_string <= IDLE_LEVEL;
                    if (r_gap_cnt == c_gap_last) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // An accept (idle, or last-bit cycle when GAP==0) overrides the above
            if (w_accept) begin
                r_busy  <= 1'b1;
                r_ready <= 1'b0;
                r_done  <= 1'b0;
                r_cnt   <= '0;
`ifdef PREAMBLE_EN
                r_state   <= S_PRE;
                r_string  <= PREAMBLE[3];
                r_pre_sh  <= {PREAMBLE[2:0], 1'b0};
                r_pre_cnt <= '0;
                r_shreg   <= data_in;
`else
                r_state  <= S_SHIFT;
                r_string <= data_in[WIDTH-1];
                r_shreg  <= {data_in[WIDTH-2:0], 1'b0};
`endif
            end
        end
    end

    assign data_ready = r_ready;
    assign string_out = r_string;
    assign busy       = r_busy;
    assign word_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pattern_generator_p2s.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_pattern_generator_p2s                                          |
// | Desc   : Directed self-checking bench for pattern_generator_p2s (GAP=1 and |
// |          GAP=0 instances, 1101 loopback detector model).                   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_pattern_generator_p2s;

`ifdef PREAMBLE_EN
    localparam int c_pre = 4;
`else
    localparam int c_pre = 0;
`endif
    localparam logic [3:0] c_pre_bits = 4'b1101;

    logic       clk;
    logic       reset;
    logic [7:0] a_data_in, b_data_in;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
    logic       a_str, b_str;
    logic       a_busy, b_busy;
    logic       a_done, b_done;

    int checks = 0;
    int errors = 0;

    pattern_generator_p2s #(.WIDTH(8), .GAP(1)) dut_a (
        .clk(clk), .reset(reset), .data_in(a_data_in), .data_valid(a_valid),
        .data_ready(a_ready), .string_out(a_str), .busy(a_busy), .word_done(a_done)
    );

    pattern_generator_p2s #(.WIDTH(8), .GAP(0)) dut_b (
        .clk(clk), .reset(reset), .data_in(b_data_in), .data_valid(b_valid),
        .data_ready(b_ready), .string_out(b_str), .busy(b_busy), .word_done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 1101 detector model with registered output, fed by dut_a
    logic [2:0] det_hist;
    logic       det_out;
    always @(posedge clk) begin
        if (reset) begin
            det_hist <= 3'b000;
            det_out  <= 1'b0;
        end else begin
            det_out  <= ({det_hist, a_str} == 4'b1101);
            det_hist <= {det_hist[1:0], a_str};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected serial bit k of a framed word (preamble bits first when enabled)
    function automatic logic exp_bit(input logic [7:0] word, input int k);
        logic [3:0] pb;
        pb = c_pre_bits;
        if (k < c_pre) return pb[3-k];
        return word[7-(k-c_pre)];
    endfunction

    task automatic test_reset;
        reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        a_data_in = 8'hFF; b_data_in = 8'hFF;
        tick; tick;
        checks += 8;
        if (a_str !== 1'b0)   begin errors++; $display("FAIL reset_a_str: got %b want 0", a_str); end
        if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready: got %b want 1", a_ready); end
        if (a_busy !== 1'b0)  begin errors++; $display("FAIL reset_a_busy: got %b want 0", a_busy); end
        if (a_done !== 1'b0)  begin errors++; $display("FAIL reset_a_done: got %b want 0", a_done); end
        if (b_str !== 1'b0)   begin errors++; $display("FAIL reset_b_str: got %b want 0", b_str); end
        if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready: got %b want 1", b_ready); end
        if (b_busy !== 1'b0)  begin errors++; $display("FAIL reset_b_busy: got %b want 0", b_busy); end
        if (b_done !== 1'b0)  begin errors++; $display("FAIL reset_b_done: got %b want 0", b_done); end
        a_valid = 1'b0; b_valid = 1'b0; reset = 1'b0;
        tick;
    endtask

    task automatic test_single_word;
        a_data_in = 8'hD5; a_valid = 1'b1;
        tick;
        a_valid = 1'b0;
        for (int k = 0; k < c_pre + 8; k++) begin
            checks += 4;
            if (a_str !== exp_bit(8'hD5, k)) begin errors++; $display("FAIL single_bit%0d: got %b want %b", k, a_str, exp_bit(8'hD5, k)); end
            if (a_done !== (k == c_pre + 7)) begin errors++; $display("FAIL single_done%0d: got %b want %b", k, a_done, (k == c_pre + 7)); end
            if (a_busy !== 1'b1)  begin errors++; $display("FAIL single_busy%0d: got %b want 1", k, a_busy); end
            if (a_ready !== 1'b0) begin errors++; $display("FAIL single_ready%0d: got %b want 0", k, a_ready); end
            tick;
        end
        checks += 4;
        if (a_str !== 1'b0)   begin errors++; $display("FAIL gap_str: got %b want 0", a_str); end
        if (a_ready !== 1'b0) begin errors++; $display("FAIL gap_ready: got %b want 0", a_ready); end
        if (a_busy !== 1'b1)  begin errors++; $display("FAIL gap_busy: got %b want 1", a_busy); end
        if (a_done !== 1'b0)  begin errors++; $display("FAIL gap_done: got %b want 0", a_done); end
        tick;
        checks += 2;
        if (a_ready !== 1'b1) begin errors++; $display("FAIL post_gap_ready: got %b want 1", a_ready); end
        if (a_busy !== 1'b0)  begin errors++; $display("FAIL post_gap_busy: got %b want 0", a_busy); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w;
        int kk;
        b_data_in = 8'hF0; b_valid = 1'b1;
        tick;
        b_data_in = 8'h0F;
        for (int k = 0; k < 2 * (c_pre + 8); k++) begin
            w  = (k < c_pre + 8) ? 8'hF0 : 8'h0F;
            kk = k % (c_pre + 8);
            checks += 2;
            if (b_str !== exp_bit(w, kk)) begin errors++; $display("FAIL b2b_bit%0d: got %b want %b", k, b_str, exp_bit(w, kk)); end
            if (b_done !== (kk == c_pre + 7)) begin errors++; $display("FAIL b2b_done%0d: got %b want %b", k, b_done, (kk == c_pre + 7)); end
            if (k == c_pre + 7) begin
                checks++;
                if (b_ready !== 1'b1) begin errors++; $display("FAIL b2b_lastbit_ready: got %b want 1", b_ready); end
            end
            tick;
            if (k == c_pre + 7) b_valid = 1'b0;
        end
        checks += 3;
        if (b_str !== 1'b0)   begin errors++; $display("FAIL b2b_end_str: got %b want 0", b_str); end
        if (b_ready !== 1'b1) begin errors++; $display("FAIL b2b_end_ready: got %b want 1", b_ready); end
        if (b_busy !== 1'b0)  begin errors++; $display("FAIL b2b_end_busy: got %b want 0", b_busy); end
    endtask

    task automatic test_reset_mid_word;
        a_data_in = 8'hFF; a_valid = 1'b1;
        tick;
        a_valid = 1'b0;
        tick; tick;
        reset = 1'b1;
        tick;
        checks += 4;
        if (a_str !== 1'b0)   begin errors++; $display("FAIL abort_str: got %b want 0", a_str); end
        if (a_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", a_ready); end
        if (a_busy !== 1'b0)  begin errors++; $display("FAIL abort_busy: got %b want 0", a_busy); end
        if (a_done !== 1'b0)  begin errors++; $display("FAIL abort_done: got %b want 0", a_done); end
        reset = 1'b0;
        a_data_in = 8'hA5; a_valid = 1'b1;
        tick;
        a_valid = 1'b0;
        for (int k = 0; k < c_pre + 8; k++) begin
            checks++;
            if (a_str !== exp_bit(8'hA5, k)) begin errors++; $display("FAIL resume_bit%0d: got %b want %b", k, a_str, exp_bit(8'hA5, k)); end
            tick;
        end
        tick;
    endtask

    task automatic test_loopback;
        tick; tick; tick; tick;
        a_data_in = 8'h0D; a_valid = 1'b1;
        tick;
        a_valid = 1'b0;
        for (int k = 1; k <= c_pre + 10; k++) begin
            checks++;
            if (det_out !== ((k == c_pre + 9) || (c_pre > 0 && k == 5))) begin
                errors++; $display("FAIL loop_0d_det_T+%0d: got %b want %b", k, det_out, ((k == c_pre + 9) || (c_pre > 0 && k == 5)));
            end
            tick;
        end
        a_data_in = 8'h0B; a_valid = 1'b1;
        tick;
        a_valid = 1'b0;
        for (int k = 1; k <= c_pre + 9; k++) begin
            checks++;
            if (det_out !== (c_pre > 0 && k == 5)) begin
                errors++; $display("FAIL loop_0b_det_T+%0d: got %b want %b", k, det_out, (c_pre > 0 && k == 5));
            end
            tick;
        end
        tick;
    endtask

`ifdef PREAMBLE_EN
    task automatic test_preamble;
        logic [3:0] pb;
        logic       e;
        pb = c_pre_bits;
        tick; tick; tick; tick;
        a_data_in = 8'h00; a_valid = 1'b1;
        tick;
        a_valid = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            e = (k <= 4) ? pb[4-k] : 1'b0;
            checks += 3;
            if (a_str !== e) begin errors++; $display("FAIL pre_bit_T+%0d: got %b want %b", k, a_str, e); end
            if (a_done !== (k == 12)) begin errors++; $display("FAIL pre_done_T+%0d: got %b want %b", k, a_done, (k == 12)); end
            if (det_out !== (k == 5)) begin errors++; $display("FAIL pre_det_T+%0d: got %b want %b", k, det_out, (k == 5)); end
            tick;
        end
        tick;
    endtask
`endif

    initial begin
        reset = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_data_in = 8'h00; b_data_in = 8'h00;
        test_reset;
        test_single_word;
        test_back_to_back;
        test_reset_mid_word;
        test_loopback;
`ifdef PREAMBLE_EN
        test_preamble;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
